// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch front end: sequencer states,
// next-PC source codes, default vectors and the branch offset helper.
package mips_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } seq_state_e;

    typedef enum logic [2:0] {
        SEL_SEQ = 3'd0,
        SEL_BR  = 3'd1,
        SEL_J   = 3'd2,
        SEL_JR  = 3'd3,
        SEL_EXC = 3'd4
    } pc_sel_e;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0000_0080;

    // Word offset -> sign-extended byte offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_select.sv
// Combinational next-PC selection: pc+4, branch/jump targets, priority
// mux and misaligned-JR trap flag.
// Ports: pc_i, redirect requests and targets, exc_vector_i in;
//        pc_plus4_o, next_pc_o, trap_o out.
module pc_next_select
    import mips_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] exc_vector_i,
    input  logic        branch_taken_i,
    input  logic [15:0] branch_imm_i,
    input  logic        jump_i,
    input  logic [25:0] jump_index_i,
    input  logic        jr_i,
    input  logic [31:0] jr_target_i,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] next_pc_o,
    output logic        trap_o
);

    pc_sel_e     sel;
    logic [31:0] br_target;
    logic [31:0] j_target;

    assign pc_plus4_o = pc_i + 32'd4;
    assign br_target  = pc_plus4_o + branch_offset(branch_imm_i);
    assign j_target   = {pc_plus4_o[31:28], jump_index_i, 2'b00};

    // Highest priority first; a misaligned JR overrides everything.
    always_comb begin
        sel = SEL_SEQ;
        if (jr_i && (jr_target_i[1:0] != 2'b00)) begin
            sel = SEL_EXC;
        end else if (jr_i) begin
            sel = SEL_JR;
        end else if (jump_i) begin
            sel = SEL_J;
        end else if (branch_taken_i) begin
            sel = SEL_BR;
        end
    end

    always_comb begin
        next_pc_o = pc_plus4_o;
        case (sel)
            SEL_SEQ: next_pc_o = pc_plus4_o;
            SEL_BR:  next_pc_o = br_target;
            SEL_J:   next_pc_o = j_target;
            SEL_JR:  next_pc_o = jr_target_i;
            SEL_EXC: next_pc_o = exc_vector_i;
            default: next_pc_o = pc_plus4_o;
        endcase
    end

    assign trap_o = (sel == SEL_EXC);

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: owns pc, the BOOT/RUN/HALT fetch FSM and the
// misaligned-JR error pulse. Ports: clk, reset, imem_ready, stall,
// redirects (branch/jump/jr), halt_req, resume in; pc, pc_plus4,
// fetch_valid, halted, addr_error out.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_imm,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        halt_req,
    input  logic        resume,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        halted,
    output logic        addr_error
);

    seq_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        addr_error_q, addr_error_d;
    logic [31:0] next_pc;
    logic        trap;
    logic        adv;

    pc_next_select u_next (
        .pc_i           (pc_q),
        .exc_vector_i   (EXC_VECTOR),
        .branch_taken_i (branch_taken),
        .branch_imm_i   (branch_imm),
        .jump_i         (jump),
        .jump_index_i   (jump_index),
        .jr_i           (jr),
        .jr_target_i    (jr_target),
        .pc_plus4_o     (pc_plus4),
        .next_pc_o      (next_pc),
        .trap_o         (trap)
    );

    assign adv = (state_q == RUN) && imem_ready && !stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= BOOT;
            pc_q         <= RESET_VECTOR;
            addr_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_error_q <= addr_error_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        fetch_valid  = 1'b0;
        halted       = 1'b0;
        pc_d         = adv ? next_pc : pc_q;
        addr_error_d = adv && trap;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                fetch_valid = 1'b1;
                // The halting fetch still commits its next PC.
                if (adv && halt_req) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                halted = 1'b1;
                if (resume) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign pc         = pc_q;
    assign addr_error = addr_error_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer: reset, sequential fetch,
// redirect priority, trap pulse, stall/handshake, halt/resume, reset.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_ready;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_imm;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic        halt_req;
    logic        resume;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        halted;
    logic        addr_error;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .imem_ready   (imem_ready),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .jump         (jump),
        .jump_index   (jump_index),
        .jr           (jr),
        .jr_target    (jr_target),
        .halt_req     (halt_req),
        .resume       (resume),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .fetch_valid  (fetch_valid),
        .halted       (halted),
        .addr_error   (addr_error)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        stall        = 1'b0;
        imem_ready   = 1'b1;
        branch_taken = 1'b0;
        branch_imm   = 16'h0;
        jump         = 1'b0;
        jump_index   = 26'h0;
        jr           = 1'b0;
        jr_target    = 32'h0;
        halt_req     = 1'b0;
        resume       = 1'b0;
    endtask

    task automatic go_to(input logic [31:0] t);
        clr();
        jr        = 1'b1;
        jr_target = t;
        step();
        clr();
    endtask

    initial begin
        clr();
        reset = 1'b1;
        #12;
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc4", pc_plus4, 32'h4);
        chk("rst_fv", {31'b0, fetch_valid}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_aerr", {31'b0, addr_error}, 32'd0);

        @(posedge clk);
        #1 reset = 1'b0;
        chk("boot_pc", pc, 32'h0);
        chk("boot_fv", {31'b0, fetch_valid}, 32'd0);
        step();
        chk("run_pc0", pc, 32'h0);
        chk("run_fv", {31'b0, fetch_valid}, 32'd1);
        step();
        chk("run_pc4", pc, 32'h4);
        step();
        chk("run_pc8", pc, 32'h8);

        go_to(32'h100);
        chk("jr_100", pc, 32'h100);
        branch_taken = 1'b1;
        branch_imm   = 16'hFFFE;
        step();
        chk("br_back", pc, 32'hFC);
        go_to(32'h100);
        branch_taken = 1'b1;
        branch_imm   = 16'h0003;
        step();
        chk("br_fwd", pc, 32'h110);

        go_to(32'h1000_0040);
        jump         = 1'b1;
        jump_index   = 26'h000_0010;
        branch_taken = 1'b1;
        branch_imm   = 16'h0100;
        step();
        chk("j_over_br", pc, 32'h1000_0040);
        jr        = 1'b1;
        jr_target = 32'h2000;
        step();
        chk("jr_over_j", pc, 32'h2000);

        clr();
        jr        = 1'b1;
        jr_target = 32'h2002;
        jump      = 1'b1;
        step();
        chk("trap_pc", pc, 32'h80);
        chk("trap_aerr", {31'b0, addr_error}, 32'd1);
        clr();
        step();
        chk("trap_aerr_clr", {31'b0, addr_error}, 32'd0);
        chk("trap_seq", pc, 32'h84);

        go_to(32'h20);
        branch_taken = 1'b1;
        branch_imm   = 16'h0004;
        stall        = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_hold", pc, 32'h20);
        end
        chk("stall_fv", {31'b0, fetch_valid}, 32'd1);
        stall = 1'b0;
        step();
        chk("stall_rel", pc, 32'h34);

        branch_imm = 16'h0001;
        imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("imem_hold", pc, 32'h34);
        end
        imem_ready = 1'b1;
        step();
        chk("imem_rel", pc, 32'h3C);

        go_to(32'hFFFF_FFFC);
        chk("wrap_pre", pc, 32'hFFFF_FFFC);
        step();
        chk("wrap", pc, 32'h0);

        go_to(32'h40);
        halt_req = 1'b1;
        stall    = 1'b1;
        step();
        chk("halt_wait_pc", pc, 32'h40);
        chk("halt_wait_h", {31'b0, halted}, 32'd0);
        stall = 1'b0;
        step();
        chk("halt_pc", pc, 32'h44);
        chk("halt_h", {31'b0, halted}, 32'd1);
        chk("halt_fv", {31'b0, fetch_valid}, 32'd0);
        clr();
        step();
        chk("halt_hold", pc, 32'h44);
        resume = 1'b1;
        step();
        chk("resume_pc", pc, 32'h44);
        chk("resume_fv", {31'b0, fetch_valid}, 32'd1);
        chk("resume_h", {31'b0, halted}, 32'd0);
        clr();
        step();
        chk("resume_seq", pc, 32'h48);

        halt_req = 1'b1;
        step();
        clr();
        chk("halt2_h", {31'b0, halted}, 32'd1);
        #3 reset = 1'b1;
        #1;
        chk("async_pc", pc, 32'h0);
        chk("async_h", {31'b0, halted}, 32'd0);
        chk("async_fv", {31'b0, fetch_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
